mmio_responder: RTL and testbench

Responder end of the processor's data-memory bus: decodes each load/store address from the single-cycle core, forwards RAM-region accesses to `DataMemory`, and serves a small register file of memory-mapped I/O. The I/O registers are an output port, a synchronized input port with sticky edge flags, a compare timer and a status register. It sits between the core's `Address/WriteData/MemWrite/MemRead/ReadData` bus and `DataMemory`, and drives the top-level `PortOut`.

---
 rtl/mmio_pkg.sv | 32 +++
 rtl/mmio_responder_input_sync.sv | 33 +++
 rtl/mmio_responder.sv | 181 ++++++++++++++++++
 tb/tb_mmio_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the data-memory bus responder: address map defaults,
// I/O register offsets and STATUS bit positions.
package mmio_pkg;

    localparam logic [31:0] RAM_BASE_DEFAULT  = 32'hEFFF_8000;
    localparam int unsigned RAM_WORDS_DEFAULT = 1024;
    localparam logic [31:0] IO_BASE_DEFAULT   = 32'hFFFF_0000;

    localparam logic [4:0] OFS_PORT_OUT  = 5'h00;
    localparam logic [4:0] OFS_PORT_IN   = 5'h04;
    localparam logic [4:0] OFS_EDGE      = 5'h08;
    localparam logic [4:0] OFS_TIMER     = 5'h0C;
    localparam logic [4:0] OFS_TIMER_CMP = 5'h10;
    localparam logic [4:0] OFS_STATUS    = 5'h14;

    localparam int unsigned STATUS_TIMER_MATCH = 0;
    localparam int unsigned STATUS_ACCESS_ERR  = 1;
    localparam int unsigned STATUS_BITS        = 2;

    localparam int unsigned PORT_IN_WIDTH = 8;
    localparam logic [31:0] TIMER_CMP_RESET = 32'hFFFF_FFFF;

    // True for the six implemented offsets inside the 32-byte I/O window.
    function automatic logic isIoOffsetUsed(input logic [4:0] ofs);
        case (ofs)
            OFS_PORT_OUT, OFS_PORT_IN, OFS_EDGE,
            OFS_TIMER, OFS_TIMER_CMP, OFS_STATUS: isIoOffsetUsed = 1'b1;
            default:                              isIoOffsetUsed = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mmio_responder_input_sync.sv
// Three-flop synchronizer for an asynchronous input bus; the second stage is
// the usable value and the third stage provides a one-cycle rising-edge pulse.
module input_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] asyncIn,
    output logic [WIDTH-1:0] syncOut,
    output logic [WIDTH-1:0] risePulse
);

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;
    logic [WIDTH-1:0] s3_r;

    // Synchronizer chain, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r <= {WIDTH{1'b0}};
            s2_r <= {WIDTH{1'b0}};
            s3_r <= {WIDTH{1'b0}};
        end else begin
            s1_r <= asyncIn;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign syncOut   = s2_r;
    assign risePulse = s2_r & ~s3_r;

endmodule

// File: rtl/mmio_responder.sv
// Data-memory bus responder: decodes core loads/stores into the RAM region or
// the memory-mapped I/O registers (output port, input port, edges, timer, status).
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = RAM_BASE_DEFAULT,
    parameter int unsigned RAM_WORDS = RAM_WORDS_DEFAULT,
    parameter logic [31:0] IO_BASE   = IO_BASE_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  Address,
    input  logic [31:0]                  WriteData,
    input  logic                         MemWrite,
    input  logic                         MemRead,
    output logic [31:0]                  ReadData,
    output logic [$clog2(RAM_WORDS)-1:0] RamAddress,
    output logic                         RamMemWrite,
    output logic                         RamMemRead,
    input  logic [31:0]                  RamReadData,
    input  logic [7:0]                   PortIn,
    output logic [31:0]                  PortOut,
    output logic                         TimerIrq
);

    localparam int unsigned RAM_IDX_W = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) * 32'd4;

    logic [31:0]              ramOffset_s;
    logic                     ramHit_s;
    logic                     ioHit_s;
    logic [4:0]               ioOfs_s;
    logic                     aligned_s;
    logic                     anyStrobe_s;
    logic                     accessErr_s;
    logic                     ioWrite_s;
    logic                     wrPortOut_s;
    logic                     wrEdge_s;
    logic                     wrTimer_s;
    logic                     wrTimerCmp_s;
    logic                     wrStatus_s;
    logic [PORT_IN_WIDTH-1:0] portInSync_s;
    logic [PORT_IN_WIDTH-1:0] portInRise_s;
    logic                     timerMatch_s;
    logic [31:0]              portOutNext_s;
    logic [PORT_IN_WIDTH-1:0] edgeNext_s;
    logic [31:0]              timerNext_s;
    logic [31:0]              timerCmpNext_s;
    logic [STATUS_BITS-1:0]   statusNext_s;
    logic [PORT_IN_WIDTH-1:0] edgeClr_s;
    logic [STATUS_BITS-1:0]   statusClr_s;
    logic [STATUS_BITS-1:0]   statusSet_s;
    logic [31:0]              ioReadData_s;

    logic [31:0]              portOut_r;
    logic [PORT_IN_WIDTH-1:0] edgeFlags_r;
    logic [31:0]              timer_r;
    logic [31:0]              timerCmp_r;
    logic [STATUS_BITS-1:0]   status_r;

    input_sync #(
        .WIDTH(PORT_IN_WIDTH)
    ) u_portInSync (
        .clk      (clk),
        .reset    (reset),
        .asyncIn  (PortIn),
        .syncOut  (portInSync_s),
        .risePulse(portInRise_s)
    );

    // Address decode and access-error classification.
    always_comb begin
        ramOffset_s = Address - RAM_BASE;
        ramHit_s    = (Address >= RAM_BASE) && (ramOffset_s < RAM_BYTES);
        ioHit_s     = (Address[31:5] == IO_BASE[31:5]);
        ioOfs_s     = Address[4:0];
        aligned_s   = (Address[1:0] == 2'b00);
        anyStrobe_s = MemWrite | MemRead;
        accessErr_s = anyStrobe_s &
                      (~aligned_s | ~(ramHit_s | (ioHit_s & isIoOffsetUsed(ioOfs_s))));
    end

    assign RamAddress  = ramOffset_s[RAM_IDX_W+1:2];
    assign RamMemWrite = MemWrite & ramHit_s & aligned_s;
    assign RamMemRead  = MemRead & ramHit_s & aligned_s;

    // Per-register write enables; an erroneous access never reaches a register.
    always_comb begin
        ioWrite_s    = MemWrite & ioHit_s & ~accessErr_s;
        wrPortOut_s  = ioWrite_s & (ioOfs_s == OFS_PORT_OUT);
        wrEdge_s     = ioWrite_s & (ioOfs_s == OFS_EDGE);
        wrTimer_s    = ioWrite_s & (ioOfs_s == OFS_TIMER);
        wrTimerCmp_s = ioWrite_s & (ioOfs_s == OFS_TIMER_CMP);
        wrStatus_s   = ioWrite_s & (ioOfs_s == OFS_STATUS);
    end

    // Next-state values; hardware set conditions win over W1C clears.
    always_comb begin
        timerMatch_s = (timer_r == timerCmp_r);

        if (wrPortOut_s) begin
            portOutNext_s = WriteData;
        end else begin
            portOutNext_s = portOut_r;
        end

        if (wrEdge_s) begin
            edgeClr_s = WriteData[PORT_IN_WIDTH-1:0];
        end else begin
            edgeClr_s = {PORT_IN_WIDTH{1'b0}};
        end
        edgeNext_s = (edgeFlags_r & ~edgeClr_s) | portInRise_s;

        // A software store to TIMER overrides both the increment and the match reload.
        if (wrTimer_s) begin
            timerNext_s = WriteData;
        end else if (timerMatch_s) begin
            timerNext_s = 32'h0000_0000;
        end else begin
            timerNext_s = timer_r + 32'd1;
        end

        if (wrTimerCmp_s) begin
            timerCmpNext_s = WriteData;
        end else begin
            timerCmpNext_s = timerCmp_r;
        end

        if (wrStatus_s) begin
            statusClr_s = WriteData[STATUS_BITS-1:0];
        end else begin
            statusClr_s = {STATUS_BITS{1'b0}};
        end
        statusSet_s                     = {STATUS_BITS{1'b0}};
        statusSet_s[STATUS_TIMER_MATCH] = timerMatch_s & ~wrTimer_s;
        statusSet_s[STATUS_ACCESS_ERR]  = accessErr_s;
        statusNext_s = (status_r & ~statusClr_s) | statusSet_s;
    end

    // I/O register state; reset discards any store presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            portOut_r   <= 32'h0000_0000;
            edgeFlags_r <= {PORT_IN_WIDTH{1'b0}};
            timer_r     <= 32'h0000_0000;
            timerCmp_r  <= TIMER_CMP_RESET;
            status_r    <= {STATUS_BITS{1'b0}};
        end else begin
            portOut_r   <= portOutNext_s;
            edgeFlags_r <= edgeNext_s;
            timer_r     <= timerNext_s;
            timerCmp_r  <= timerCmpNext_s;
            status_r    <= statusNext_s;
        end
    end

    // I/O read mux and load-data select; errors and non-loads read as zero.
    always_comb begin
        case (ioOfs_s)
            OFS_PORT_OUT:  ioReadData_s = portOut_r;
            OFS_PORT_IN:   ioReadData_s = {24'h00_0000, portInSync_s};
            OFS_EDGE:      ioReadData_s = {24'h00_0000, edgeFlags_r};
            OFS_TIMER:     ioReadData_s = timer_r;
            OFS_TIMER_CMP: ioReadData_s = timerCmp_r;
            OFS_STATUS:    ioReadData_s = {30'h0000_0000, status_r};
            default:       ioReadData_s = 32'h0000_0000;
        endcase

        if (!MemRead || accessErr_s) begin
            ReadData = 32'h0000_0000;
        end else if (ramHit_s) begin
            ReadData = RamReadData;
        end else begin
            ReadData = ioReadData_s;
        end
    end

    assign PortOut  = portOut_r;
    assign TimerIrq = status_r[STATUS_TIMER_MATCH];

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder: reset values, I/O register
// behaviour, RAM forwarding, timer match and access-error handling.
module tb_mmio_responder;
    import mmio_pkg::*;

    localparam logic [31:0] RB        = RAM_BASE_DEFAULT;
    localparam logic [31:0] IB        = IO_BASE_DEFAULT;
    localparam logic [31:0] RAM_RDATA = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic [9:0]  RamAddress;
    logic        RamMemWrite;
    logic        RamMemRead;
    logic [31:0] RamReadData;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic        TimerIrq;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    mmio_responder dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .WriteData  (WriteData),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .ReadData   (ReadData),
        .RamAddress (RamAddress),
        .RamMemWrite(RamMemWrite),
        .RamMemRead (RamMemRead),
        .RamReadData(RamReadData),
        .PortIn     (PortIn),
        .PortOut    (PortOut),
        .TimerIrq   (TimerIrq)
    );

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic busIdle();
        Address   = 32'h0000_0000;
        WriteData = 32'h0000_0000;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
    endtask

    task automatic expectLoad(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        Address  = addr;
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        #1;
        checkEq(tag, ReadData, exp);
        busIdle();
    endtask

    task automatic doStore(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        tick(1);
        busIdle();
    endtask

    logic [31:0] errAddr  [6];
    logic        errWrite [6];

    initial begin
        errAddr  = '{IB + 32'h2, 32'h0000_0000, IB + 32'h18, RB - 32'h4, RB + 32'h1000, RB + 32'h1};
        errWrite = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset       = 1'b1;
        PortIn      = 8'h00;
        RamReadData = RAM_RDATA;
        busIdle();
        tick(3);
        reset = 1'b0;

        // Reset state, cycle 0 after reset release
        checkEq("rst_portout", PortOut, 32'h0);
        checkEq("rst_irq", {31'h0, TimerIrq}, 32'h0);
        expectLoad("rst_port_out", IB + 32'h00, 32'h0);
        expectLoad("rst_port_in", IB + 32'h04, 32'h0);
        expectLoad("rst_edge", IB + 32'h08, 32'h0);
        expectLoad("rst_timer", IB + 32'h0C, 32'h0);
        expectLoad("rst_cmp", IB + 32'h10, 32'hFFFF_FFFF);
        expectLoad("rst_status", IB + 32'h14, 32'h0);
        tick(3);
        expectLoad("timer_cycle3", IB + 32'h0C, 32'd3);

        // Output port and RAM forwarding
        doStore(IB, 32'hDEAD_BEEF);
        checkEq("portout_store", PortOut, 32'hDEAD_BEEF);
        expectLoad("portout_load", IB, 32'hDEAD_BEEF);

        Address = RB + 32'h10; WriteData = 32'h1111_2222; MemWrite = 1'b1; MemRead = 1'b0;
        #1;
        checkEq("ram_wr_addr", {22'h0, RamAddress}, 32'd4);
        checkEq("ram_wr_strobe", {31'h0, RamMemWrite}, 32'h1);
        checkEq("ram_wr_nord", {31'h0, RamMemRead}, 32'h0);
        tick(1);
        busIdle();
        checkEq("ram_wr_portout", PortOut, 32'hDEAD_BEEF);

        Address = RB + 32'hFFC; MemRead = 1'b1;
        #1;
        checkEq("ram_last_addr", {22'h0, RamAddress}, 32'd1023);
        checkEq("ram_last_rd", {31'h0, RamMemRead}, 32'h1);
        checkEq("ram_last_data", ReadData, RAM_RDATA);
        busIdle();

        // Simultaneous load and store: old value read, new value committed
        Address = IB; WriteData = 32'h0BAD_F00D; MemWrite = 1'b1; MemRead = 1'b1;
        #1;
        checkEq("rw_readdata", ReadData, 32'hDEAD_BEEF);
        tick(1);
        busIdle();
        checkEq("rw_portout", PortOut, 32'h0BAD_F00D);
        doStore(IB, 32'hDEAD_BEEF);

        // Input port synchronizer and edge flags
        PortIn = 8'h81;
        tick(2);
        expectLoad("portin_sync", IB + 32'h04, 32'h81);
        expectLoad("edge_early", IB + 32'h08, 32'h0);
        tick(1);
        expectLoad("edge_set", IB + 32'h08, 32'h81);
        doStore(IB + 32'h08, 32'h01);
        expectLoad("edge_w1c", IB + 32'h08, 32'h80);
        doStore(IB + 32'h04, 32'hFF);
        expectLoad("portin_ro", IB + 32'h04, 32'h81);
        expectLoad("portin_noerr", IB + 32'h14, 32'h0);
        PortIn = 8'h80;
        tick(3);
        PortIn = 8'h81;
        tick(2);
        doStore(IB + 32'h08, 32'h01);
        expectLoad("edge_setwins", IB + 32'h08, 32'h81);
        doStore(IB + 32'h08, 32'h81);
        expectLoad("edge_clr_all", IB + 32'h08, 32'h0);

        // Timer compare, reload and store override
        doStore(IB + 32'h10, 32'd5);
        doStore(IB + 32'h0C, 32'd0);
        expectLoad("tmr_zero", IB + 32'h0C, 32'd0);
        tick(5);
        expectLoad("tmr_five", IB + 32'h0C, 32'd5);
        checkEq("tmr_irq_pre", {31'h0, TimerIrq}, 32'h0);
        tick(1);
        checkEq("tmr_irq_set", {31'h0, TimerIrq}, 32'h1);
        expectLoad("tmr_status1", IB + 32'h14, 32'h1);
        expectLoad("tmr_reload", IB + 32'h0C, 32'd0);
        tick(1);
        expectLoad("tmr_after", IB + 32'h0C, 32'd1);
        doStore(IB + 32'h14, 32'h1);
        expectLoad("tmr_stat_clr", IB + 32'h14, 32'h0);
        checkEq("tmr_irq_clr", {31'h0, TimerIrq}, 32'h0);
        tick(3);
        expectLoad("tmr_five_b", IB + 32'h0C, 32'd5);
        doStore(IB + 32'h0C, 32'd5);
        expectLoad("tmr_ovr_stat", IB + 32'h14, 32'h0);
        expectLoad("tmr_ovr_val", IB + 32'h0C, 32'd5);
        tick(1);
        expectLoad("tmr_rematch", IB + 32'h14, 32'h1);
        doStore(IB + 32'h10, 32'hFFFF_FFFF);
        doStore(IB + 32'h14, 32'h3);
        expectLoad("tmr_final_clr", IB + 32'h14, 32'h0);

        // Access errors
        for (int i = 0; i < 6; i++) begin
            Address = errAddr[i]; WriteData = 32'h77;
            MemWrite = errWrite[i]; MemRead = ~errWrite[i];
            #1;
            checkEq($sformatf("err%0d_rdata", i), ReadData, 32'h0);
            checkEq($sformatf("err%0d_ramwr", i), {31'h0, RamMemWrite}, 32'h0);
            checkEq($sformatf("err%0d_ramrd", i), {31'h0, RamMemRead}, 32'h0);
            tick(1);
            busIdle();
            expectLoad($sformatf("err%0d_status", i), IB + 32'h14, 32'h2);
            checkEq($sformatf("err%0d_portout", i), PortOut, 32'hDEAD_BEEF);
            doStore(IB + 32'h14, 32'h2);
            expectLoad($sformatf("err%0d_clr", i), IB + 32'h14, 32'h0);
        end

        // Reset mid-run with a concurrent store
        doStore(IB, 32'h55);
        checkEq("pre_rst_portout", PortOut, 32'h55);
        PortIn = 8'h00;
        tick(3);
        PortIn = 8'h81;
        tick(3);
        Address = 32'h0; MemRead = 1'b1;
        tick(1);
        busIdle();
        tick(2);
        reset = 1'b1;
        doStore(IB, 32'hAA);
        reset = 1'b0;
        checkEq("rst2_portout", PortOut, 32'h0);
        checkEq("rst2_irq", {31'h0, TimerIrq}, 32'h0);
        expectLoad("rst2_port_out", IB + 32'h00, 32'h0);
        expectLoad("rst2_port_in", IB + 32'h04, 32'h0);
        expectLoad("rst2_edge", IB + 32'h08, 32'h0);
        expectLoad("rst2_timer", IB + 32'h0C, 32'h0);
        expectLoad("rst2_cmp", IB + 32'h10, 32'hFFFF_FFFF);
        expectLoad("rst2_status", IB + 32'h14, 32'h0);
        tick(2);
        expectLoad("rst2_port_in_b", IB + 32'h04, 32'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
